// File: rtl/whack_game_core.sv
// rtl/whack_game_core.sv - timed whack-a-mole round: LFSR moles, countdown, saturating score
module whack_game_core #(
  parameter int          NUM_HOLES     = 5,
  parameter int          IDX_W         = 4,
  parameter int          TICKS_PER_SEC = 50000000,
  parameter int          MOLE_TICKS    = 25000000,
  parameter int          GAME_SECONDS  = 60,
  parameter int          CD_W          = 6,
  parameter int          SCORE_W       = 8,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic                 hit_valid,
  input  logic [IDX_W-1:0]     hit_index,
  input  logic                 penalty_mode,
  output logic [NUM_HOLES-1:0] moles,
  output logic [1:0]           state,
  output logic [CD_W-1:0]      countdown,
  output logic [SCORE_W-1:0]   score,
  output logic                 mole_hit,
  output logic                 miss,
  output logic                 game_over
);

  localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int MOLE_W = (MOLE_TICKS > 1) ? $clog2(MOLE_TICKS) : 1;
  localparam logic [4:0] HOLES5 = 5'(NUM_HOLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [NUM_HOLES-1:0]   moles_q, moles_d;
  logic [CD_W-1:0]        cd_q, cd_d;
  logic [SCORE_W-1:0]     score_q, score_d;
  logic [SEC_W-1:0]       sec_q, sec_d;
  logic [MOLE_W-1:0]      mole_cnt_q, mole_cnt_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   mole_hit_q, mole_hit_d;
  logic                   miss_q, miss_d;
  logic                   game_over_q, game_over_d;

  logic [NUM_HOLES-1:0]   raw_mask, gen_mask, hit_onehot;
  logic [4:0]             fallback_sel;
  logic                   hit_ok, sec_wrap, mole_wrap;

  // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // An all-zero draw is replaced by a single mole so a loaded board is never empty.
  assign raw_mask     = lfsr_q[NUM_HOLES-1:0];
  assign fallback_sel = {1'b0, lfsr_q[3:0]} % HOLES5;
  assign gen_mask     = (raw_mask != '0) ? raw_mask : (NUM_HOLES'(1) << fallback_sel);

  // Out-of-range indices shift the one-hot to zero, so they count as misses.
  assign hit_onehot = NUM_HOLES'(1) << hit_index;
  assign hit_ok     = (moles_q & hit_onehot) != '0;
  assign sec_wrap   = sec_q == SEC_W'(TICKS_PER_SEC - 1);
  assign mole_wrap  = mole_cnt_q == MOLE_W'(MOLE_TICKS - 1);

  always_comb begin
    state_d     = state_q;
    moles_d     = moles_q;
    cd_d        = cd_q;
    score_d     = score_q;
    sec_d       = sec_q;
    mole_cnt_d  = mole_cnt_q;
    game_over_d = game_over_q;
    mole_hit_d  = 1'b0;
    miss_d      = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          state_d     = S_PLAY;
          cd_d        = CD_W'(GAME_SECONDS);
          score_d     = '0;
          sec_d       = '0;
          mole_cnt_d  = '0;
          game_over_d = 1'b0;
          moles_d     = gen_mask;
        end
      end
      S_PLAY: begin
        if (hit_valid) begin
          if (hit_ok) begin
            mole_hit_d = 1'b1;
            moles_d    = moles_q & ~hit_onehot;
            if (score_q != '1) score_d = score_q + SCORE_W'(1);
          end else begin
            miss_d = 1'b1;
            if (penalty_mode && score_q != '0) score_d = score_q - SCORE_W'(1);
          end
        end

        // Refresh overrides the hit clear; an emptied board refreshes one cycle later.
        if (moles_q == '0 || mole_wrap) begin
          moles_d    = gen_mask;
          mole_cnt_d = '0;
        end else begin
          mole_cnt_d = mole_cnt_q + MOLE_W'(1);
        end

        if (sec_wrap) begin
          sec_d = '0;
          if (cd_q == CD_W'(1)) begin
            cd_d        = '0;
            moles_d     = '0;
            state_d     = S_OVER;
            game_over_d = 1'b1;
          end else begin
            cd_d = cd_q - CD_W'(1);
          end
        end else begin
          sec_d = sec_q + SEC_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      moles_q     <= '0;
      cd_q        <= CD_W'(GAME_SECONDS);
      score_q     <= '0;
      sec_q       <= '0;
      mole_cnt_q  <= '0;
      lfsr_q      <= LFSR_SEED;
      mole_hit_q  <= 1'b0;
      miss_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      moles_q     <= moles_d;
      cd_q        <= cd_d;
      score_q     <= score_d;
      sec_q       <= sec_d;
      mole_cnt_q  <= mole_cnt_d;
      lfsr_q      <= lfsr_d;
      mole_hit_q  <= mole_hit_d;
      miss_q      <= miss_d;
      game_over_q <= game_over_d;
    end
  end

  assign moles     = moles_q;
  assign state     = state_q;
  assign countdown = cd_q;
  assign score     = score_q;
  assign mole_hit  = mole_hit_q;
  assign miss      = miss_q;
  assign game_over = game_over_q;

endmodule
